// File: rtl/hub75_bcm_pkg.sv
// Shared definitions for the HUB75 binary-code-modulation sequencer:
// FSM state encoding and the on-timer width helper.
package hub75_bcm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHIFT = 3'd1,
      ST_WAIT  = 3'd2,
      ST_LATCH = 3'd3,
      ST_ON    = 3'd4
   } state_e;

   // Wide enough to hold LSB_LEN << (N_PLANES-1) without overflow.
   function automatic int tmr_width(input int lsb_len, input int n_planes);
      return $clog2(lsb_len) + n_planes;
   endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Loadable down-counter for the unblank period; zero_q is the registered
// idle flag and drives the panel blank line directly.
module hub75_bcm_timer #(
   parameter int TMR_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             zero
);

   logic [TMR_W-1:0] count_q, count_d;
   logic             zero_q, zero_d;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - TMR_W'(1);
      end
      zero_d = (count_d == '0);
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         zero_q  <= 1'b1;
      end else begin
         count_q <= count_d;
         zero_q  <= zero_d;
      end
   end

   assign zero = zero_q;

endmodule

// File: rtl/hub75_bcm.sv
// BCM sequencer: per bit plane requests a column shift, latches it, drives
// the row address and unblanks for LSB_LEN * 2^plane cycles.
module hub75_bcm
   import hub75_bcm_pkg::*;
#(
   parameter int N_ROWS       = 32,
   parameter int N_PLANES     = 8,
   parameter int LSB_LEN      = 4,
   parameter int LOG_N_ROWS   = $clog2(N_ROWS),
   parameter int LOG_N_PLANES = $clog2(N_PLANES),
   parameter int TMR_W        = tmr_width(LSB_LEN, N_PLANES)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [LOG_N_ROWS-1:0]   row,
   input  logic                    go,
   output logic                    rdy,
   output logic [LOG_N_PLANES-1:0] shift_plane,
   output logic                    shift_go,
   input  logic                    shift_rdy,
   output logic [LOG_N_ROWS-1:0]   phy_addr,
   output logic                    phy_le,
   output logic                    phy_blank
);

   localparam logic [LOG_N_PLANES-1:0] LAST_PLANE = LOG_N_PLANES'(N_PLANES - 1);

   state_e                  state_q, state_d;
   logic [LOG_N_ROWS-1:0]   row_q, row_d;
   logic [LOG_N_ROWS-1:0]   addr_q, addr_d;
   logic [LOG_N_PLANES-1:0] plane_q, plane_d;
   logic                    le_q, le_d;
   logic                    tmr_load;
   logic                    tmr_zero;
   logic [TMR_W-1:0]        tmr_val;

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      addr_d   = addr_q;
      plane_d  = plane_q;
      tmr_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               row_d   = row;
               plane_d = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: state_d = ST_WAIT;
         ST_WAIT: begin
            // Previous plane must finish its full on-time before the address moves.
            if (shift_rdy && tmr_zero) begin
               addr_d  = row_q;
               state_d = ST_LATCH;
            end
         end
         ST_LATCH: state_d = ST_ON;
         ST_ON: begin
            tmr_load = 1'b1;
            if (plane_q == LAST_PLANE) begin
               state_d = ST_IDLE;
            end else begin
               plane_d = plane_q + LOG_N_PLANES'(1);
               state_d = ST_SHIFT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Delayed one cycle so the address is stable a cycle before le rises.
      le_d = (state_q == ST_LATCH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         addr_q  <= '0;
         plane_q <= '0;
         le_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         plane_q <= plane_d;
         le_q    <= le_d;
      end
   end

   assign tmr_val = TMR_W'(LSB_LEN) << plane_q;

   hub75_bcm_timer #(
      .TMR_W(TMR_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (tmr_load),
      .load_val(tmr_val),
      .zero    (tmr_zero)
   );

   assign rdy         = (state_q == ST_IDLE);
   assign shift_go    = (state_q == ST_SHIFT);
   assign shift_plane = plane_q;
   assign phy_addr    = addr_q;
   assign phy_le      = le_q;
   assign phy_blank   = tmr_zero;

endmodule

// File: tb/tb_hub75_bcm.sv
// Self-checking bench for hub75_bcm: a busy-time shifter model, a per-cycle
// event monitor and an expected event list built per accepted row.
module tb_hub75_bcm;

   localparam int N_ROWS   = 4;
   localparam int N_PLANES = 3;
   localparam int LSB_LEN  = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] row = '0;
   logic       go  = 1'b0;
   logic       rdy;
   logic [1:0] shift_plane;
   logic       shift_go;
   logic       shift_rdy = 1'b1;
   logic [1:0] phy_addr;
   logic       phy_le;
   logic       phy_blank;

   int n_checks = 0;
   int n_fail   = 0;

   int busy_len = 5;
   int busy_cnt = 0;
   int run_len  = 0;
   int run_addr = 0;
   bit le_pending   = 0;
   bit overlap_seen = 0;

   int q_shift[$], q_le[$], q_run[$], q_run_addr[$];
   int e_shift[$], e_le[$], e_run[$], e_run_addr[$];

   hub75_bcm #(
      .N_ROWS  (N_ROWS),
      .N_PLANES(N_PLANES),
      .LSB_LEN (LSB_LEN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .row        (row),
      .go         (go),
      .rdy        (rdy),
      .shift_plane(shift_plane),
      .shift_go   (shift_go),
      .shift_rdy  (shift_rdy),
      .phy_addr   (phy_addr),
      .phy_le     (phy_le),
      .phy_blank  (phy_blank)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Monitor and shifter model, both sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            run_len    = 0;
            le_pending = 0;
            busy_cnt   = 0;
            shift_rdy  = 1'b1;
         end else begin
            if (shift_go) begin
               check("shift_when_shifter_idle", shift_rdy, 1);
               q_shift.push_back(int'(shift_plane));
            end
            if (phy_le) begin
               check("le_after_shift_done", shift_rdy, 1);
               check("le_while_dark", phy_blank, 1);
               q_le.push_back(int'(phy_addr));
               le_pending = 1;
            end
            if (!phy_blank) begin
               if (run_len == 0) begin
                  check("lit_only_after_le", le_pending, 1);
                  le_pending = 0;
                  run_addr   = int'(phy_addr);
               end else begin
                  check("addr_stable_while_lit", phy_addr, run_addr);
               end
               run_len++;
               if (shift_go && shift_plane == 2'd0) overlap_seen = 1;
            end else if (run_len != 0) begin
               q_run.push_back(run_len);
               q_run_addr.push_back(run_addr);
               run_len = 0;
            end
            if (shift_go) begin
               shift_rdy = 1'b0;
               busy_cnt  = busy_len;
            end else if (busy_cnt > 0) begin
               busy_cnt--;
               if (busy_cnt == 0) shift_rdy = 1'b1;
            end
         end
      end
   end

   // Every plane of an accepted row: one shift, one latch at that row, one
   // lit run of LSB_LEN * 2^plane cycles at that row.
   task automatic expect_row(input int r);
      for (int p = 0; p < N_PLANES; p++) begin
         e_shift.push_back(p);
         e_le.push_back(r);
         e_run.push_back(LSB_LEN * (2 ** p));
         e_run_addr.push_back(r);
      end
   endtask

   task automatic clear_all();
      q_shift.delete(); q_le.delete(); q_run.delete(); q_run_addr.delete();
      e_shift.delete(); e_le.delete(); e_run.delete(); e_run_addr.delete();
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_n_shift"}, q_shift.size(), e_shift.size());
      check({tag, "_n_le"}, q_le.size(), e_le.size());
      check({tag, "_n_run"}, q_run.size(), e_run.size());
      while (q_shift.size() > 0 && e_shift.size() > 0)
         check({tag, "_shift_plane"}, q_shift.pop_front(), e_shift.pop_front());
      while (q_le.size() > 0 && e_le.size() > 0)
         check({tag, "_le_addr"}, q_le.pop_front(), e_le.pop_front());
      while (q_run.size() > 0 && e_run.size() > 0)
         check({tag, "_lit_len"}, q_run.pop_front(), e_run.pop_front());
      while (q_run_addr.size() > 0 && e_run_addr.size() > 0)
         check({tag, "_lit_addr"}, q_run_addr.pop_front(), e_run_addr.pop_front());
      clear_all();
   endtask

   task automatic start_row(input int r);
      @(negedge clk);
      row = 2'(r);
      go  = 1'b1;
      @(negedge clk);
      go  = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      int n = 0;
      while (!(rdy && phy_blank && busy_cnt == 0) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_in_time"}, n < max_cyc, 1);
   endtask

   initial begin
      int n;
      int r;

      // Idle after reset
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("reset_blank", phy_blank, 1);
      check("reset_rdy", rdy, 1);
      check("reset_le", phy_le, 0);
      check("reset_addr", phy_addr, 0);
      check("reset_no_shift", q_shift.size(), 0);

      // Row 2, with a go issued mid-row that must be ignored
      busy_len = 5;
      start_row(2);
      expect_row(2);
      n = 0;
      while (q_shift.size() < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("row2_second_shift_in_time", n < 200, 1);
      check("rdy_low_mid_row", rdy, 0);
      row = 2'd0;
      go  = 1'b1;
      @(negedge clk);
      go  = 1'b0;
      wait_done("row2", 400);
      compare_all("row2");

      // Slow shifter: blank holds, on-times unchanged
      busy_len = 20;
      start_row(0);
      expect_row(0);
      wait_done("slow", 800);
      compare_all("slow");

      // Back-to-back rows: next row's first shift overlaps the MSB display
      busy_len     = 5;
      overlap_seen = 0;
      start_row(1);
      expect_row(1);
      n = 0;
      while (!rdy && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("row1_rdy_in_time", n < 400, 1);
      check("rdy_during_msb_lit", phy_blank, 0);
      row = 2'd3;
      go  = 1'b1;
      expect_row(3);
      @(negedge clk);
      go  = 1'b0;
      wait_done("b2b", 800);
      check("shift_overlaps_msb", overlap_seen, 1);
      compare_all("b2b");

      // Reset in the middle of the plane-1 display
      busy_len = 3;
      start_row(1);
      n = 0;
      while (!(q_le.size() == 2 && !phy_blank) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("plane1_lit_in_time", n < 400, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_blank", phy_blank, 1);
      check("midrst_rdy", rdy, 1);
      check("midrst_shift_go", shift_go, 0);
      check("midrst_le", phy_le, 0);
      check("midrst_addr", phy_addr, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      clear_all();
      @(negedge clk);
      start_row(2);
      expect_row(2);
      wait_done("after_rst", 400);
      compare_all("after_rst");

      // Randomized rows, shifter busy times and spurious go pulses
      for (int i = 0; i < 8; i++) begin
         busy_len = int'($urandom_range(1, 25));
         r        = int'($urandom_range(0, N_ROWS - 1));
         repeat ($urandom_range(0, 4)) @(negedge clk);
         start_row(r);
         expect_row(r);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 10)) @(negedge clk);
            check("rand_rdy_low_mid_row", rdy, 0);
            row = 2'($urandom_range(0, N_ROWS - 1));
            go  = 1'b1;
            @(negedge clk);
            go  = 1'b0;
         end
         wait_done("rand", 1000);
         compare_all("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
